// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter and frame sequencer that shares one byte-wide UART
// serializer between NUM_REQ requesters. One frame in flight at a time:
// LOAD (start pulse + ack) -> WAIT_BUSY -> WAIT_DONE -> GAP -> IDLE.
// Optional handshake watchdog: define UART_TX_WDOG_EN to enable it. Without it, the wait
// states block indefinitely and o_timeout_err stays 0.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned WDOG_CYCLES = 131071
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WDOG_W = 17;

  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // Where a completed frame goes: the gap state only exists when a gap is configured.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [7:0]         byte_q, byte_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [NUM_REQ-1:0] ack_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               start_d;
  logic [7:0]         data_d;
  logic               busy_d;
  logic               timeout_d;

  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [7:0]         rr_byte;
  int unsigned        cand;
  logic               wdog_hit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

  // Round-robin search: first asserted request after the last served index, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!rr_found && i_req[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // Byte slice of the requester chosen by the round-robin search.
  always_comb begin
    rr_byte = 8'h00;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rr_idx == IDX_W'(k)) rr_byte = i_data[8*k +: 8];
    end
  end

`ifdef UART_TX_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q;

  // Per-phase watchdog count: restarts on every state change, advances while waiting on the serializer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_d != state_q) begin
      wdog_q <= '0;
    end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  assign wdog_hit = (wdog_q == WDOG_LAST);
`else
  // Watchdog compiled out; its limit is a don't-care here.
  assign wdog_hit = 1'b0 & (WDOG_CYCLES != 0);
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    ack_d     = '0;
    start_d   = 1'b0;
    grant_d   = o_grant;
    data_d    = o_tx_data;
    timeout_d = o_timeout_err;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          sel_d   = rr_idx;
          byte_d  = rr_byte;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        start_d = 1'b1;
        ack_d   = onehot(sel_q);
        grant_d = onehot(sel_q);
        data_d  = byte_q;
        ptr_d   = sel_q;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (i_tx_done) begin
          // Serializer finished before busy was ever seen.
          grant_d = '0;
          gap_d   = '0;
          state_d = AFTER_FRAME;
        end else if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = AFTER_FRAME;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RST;
      sel_q         <= '0;
      byte_q        <= 8'h00;
      gap_q         <= '0;
      o_ack         <= '0;
      o_grant       <= '0;
      o_tx_start    <= 1'b0;
      o_tx_data     <= 8'h00;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      byte_q        <= byte_d;
      gap_q         <= gap_d;
      o_ack         <= ack_d;
      o_grant       <= grant_d;
      o_tx_start    <= start_d;
      o_tx_data     <= data_d;
      o_busy        <= busy_d;
      o_timeout_err <= timeout_d;
    end
  end

endmodule
